a5_1_decryptor: RTL and testbench
=================================

# a5_1_decryptor

Receive-side A5/1 stream cipher core: loads a 64-bit session key and 22-bit frame number, runs the standard A5/1 key setup, then decrypts a bit-serial ciphertext burst by XORing each accepted bit with the keystream. It is the receiver counterpart of the `A5_1` encryptor and produces the plaintext the encryptor consumed. It sits between the burst deframer (ciphertext source) and the payload sink, with valid/ready handshakes on both sides.

## Interface
- `BURST_LEN`, 114: ciphertext bits decrypted per `start`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a frame; sampled only in IDLE.
- `key` in 64: session key; bit `key[i]` is key bit i; sampled on accepted `start`.
- `frame` in 22: frame number; `frame[i]` is frame bit i; sampled on accepted `start`.
- `c_valid` in 1: ciphertext bit valid.
- `c_bit` in 1: ciphertext bit.
- `c_ready` out 1: core accepts `c_bit` this cycle.
- `p_valid` out 1: plaintext bit valid.
- `p_bit` out 1: plaintext bit.
- `p_last` out 1: qualifies the final (`BURST_LEN`-th) plaintext bit.
- `p_ready` in 1: sink accepts `p_bit`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Registers: R1 19b (taps 13,16,17,18; clock bit 8), R2 22b (taps 20,21; clock bit 10), R3 23b (taps 7,20,21,22; clock bit 10). Shift inserts feedback at bit 0. Keystream z = R1[18]^R2[21]^R3[22].
- States: IDLE → CLEAR → KEY → FRAME → MIX → (SKIP) → STREAM → IDLE.
- IDLE: `start`=1 latches `key`/`frame` and moves to CLEAR.
- CLEAR (1 cycle): R1/R2/R3 ← 0.
- KEY (64 cycles, i=0..63): all three registers shift, then key bit i is XORed into bit 0 of each.
- FRAME (22 cycles): same as KEY with frame bits 0..21.
- MIX (100 cycles): majority clocking; a register steps iff its clock bit equals the majority of the three clock bits. Output discarded.
- STREAM: each accepted ciphertext bit (`c_valid & c_ready`) majority-clocks once; z is computed from post-clock state; `p_bit` ← `c_bit ^ z`. Keystream never advances without an accepted input bit.
- Bit counter 0..`BURST_LEN`-1; on the `BURST_LEN`-th accept, `p_last` set with that output bit and the FSM returns to IDLE.
- `start` while `busy` is ignored; `key`/`frame` changes after accept have no effect.

## Timing
- Reset values: `c_ready`=0, `p_valid`=0, `p_bit`=0, `p_last`=0, `busy`=0, all LFSRs 0, FSM IDLE. Reset mid-frame aborts immediately; any pending output bit is dropped.
- Setup latency: `start` accept at cycle 0 → `c_ready` can first be high at cycle 187 (1+64+22+100), or 301 with SKIP.
- Output register: one-bit skid-free stage. `c_ready` = STREAM & (!`p_valid` | `p_ready`). Plaintext appears on `p_valid` the cycle after input accept (latency 1). Full throughput one bit/cycle when `p_ready` held high.
- `p_valid` holds with stable `p_bit`/`p_last` until `p_ready`. Simultaneous output drain and input accept in one cycle is legal.
- After last accept, `busy` falls next cycle; last output may still be pending. A new `start` is accepted in IDLE even while that bit is pending; `c_ready` stays low until the pending bit drains.

## Configuration
- `A51_DEC_UPLINK_EN` defined: SKIP state inserted after MIX, majority-clocking `BURST_LEN` times with output discarded, so the core decrypts the second (uplink) half of the 228-bit keystream.
- Undefined: no SKIP state; MIX goes directly to STREAM; the first `BURST_LEN` keystream bits (downlink) are used.

## Test plan
- Known vector: `key`=64'hEFCDAB8967452312, `frame`=22'h134, all-zero ciphertext, `p_ready`=1 → first 16 plaintext bits 0x534E (macro off) / 0x24FD (macro on); 114 bits total, `p_last` on bit 114 only.
- Round trip: encrypt 114 random bits with the `A5_1` encryptor using the same key/frame, feed the result → plaintext matches the original bit-for-bit.
- Backpressure: random `p_ready` (50%) and `c_valid` gaps → same plaintext stream as the known-vector test; no bit lost or duplicated; `p_bit` stable while stalled.
- Setup latency: `start` at cycle 0 → `c_ready` low through cycle 186, high at cycle 187 (301 with macro); `start` pulses during setup ignored.
- Reset mid-STREAM after 40 bits: `reset_n` low → all outputs 0 asynchronously; a fresh `start` with the vector key reproduces 0x534E from bit 0.
- Back-to-back frames: `frame` 0x134 then 0x135, `start` issued in IDLE while the last bit is pending → second burst is correct, and its first `c_ready` comes no earlier than the drain of the pending bit.

Source files
------------

// File: rtl/a5_1_decryptor_if.sv
// A5/1 decryptor stream bundle: ciphertext in, plaintext out.
// master drives ciphertext and sink ready; slave is the core.
interface a5_1_decryptor_if;
   logic c_valid;
   logic c_bit;
   logic c_ready;
   logic p_valid;
   logic p_bit;
   logic p_last;
   logic p_ready;

   modport master (
      output c_valid, c_bit, p_ready,
      input  c_ready, p_valid, p_bit, p_last
   );

   modport slave (
      input  c_valid, c_bit, p_ready,
      output c_ready, p_valid, p_bit, p_last
   );
endinterface

// File: rtl/a5_1_decryptor.sv
// Receive-side A5/1 core: key setup, then bit-serial XOR decrypt.
// Define A51_DEC_UPLINK_EN to skip the downlink half of the keystream.
module a5_1_decryptor #(
   parameter int BURST_LEN = 114
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [63:0] key,
   input  logic [21:0] frame,
   output logic        busy,
   a5_1_decryptor_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_KEY,
      S_FRAME,
      S_MIX,
      S_SKIP,
      S_STREAM
   } state_t;

   localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

   state_t      r_state;
   state_t      w_nxt;
   logic [7:0]  r_cnt;
   logic [63:0] r_key;
   logic [21:0] r_frm;
   logic [18:0] r_r1;
   logic [21:0] r_r2;
   logic [22:0] r_r3;
   logic        r_pv;
   logic        r_pb;
   logic        r_pl;

   logic        w_acc;
   logic        w_in;
   logic        w_f1;
   logic        w_f2;
   logic        w_f3;
   logic        w_maj;
   logic [18:0] w_m1;
   logic [21:0] w_m2;
   logic [22:0] w_m3;
   logic        w_z;

   assign w_acc = (r_state == S_STREAM) & bus.c_valid & bus.c_ready;
   assign w_in  = (r_state == S_KEY) ? r_key[r_cnt[5:0]]
                                     : r_frm[r_cnt[4:0]];

   assign w_f1 = r_r1[13] ^ r_r1[16] ^ r_r1[17] ^ r_r1[18];
   assign w_f2 = r_r2[20] ^ r_r2[21];
   assign w_f3 = r_r3[7] ^ r_r3[20] ^ r_r3[21] ^ r_r3[22];

   assign w_maj = (r_r1[8] & r_r2[10]) |
                  (r_r1[8] & r_r3[10]) |
                  (r_r2[10] & r_r3[10]);

   assign w_m1 = (r_r1[8] == w_maj) ? {r_r1[17:0], w_f1} : r_r1;
   assign w_m2 = (r_r2[10] == w_maj) ? {r_r2[20:0], w_f2} : r_r2;
   assign w_m3 = (r_r3[10] == w_maj) ? {r_r3[21:0], w_f3} : r_r3;

   // keystream bit taken after the majority step of this accept
   assign w_z = w_m1[18] ^ w_m2[21] ^ w_m3[22];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (start) w_nxt = S_CLEAR;
         S_CLEAR:  w_nxt = S_KEY;
         S_KEY:    if (r_cnt == 8'd63) w_nxt = S_FRAME;
         S_FRAME:  if (r_cnt == 8'd21) w_nxt = S_MIX;
`ifdef A51_DEC_UPLINK_EN
         S_MIX:    if (r_cnt == 8'd99) w_nxt = S_SKIP;
`else
         S_MIX:    if (r_cnt == 8'd99) w_nxt = S_STREAM;
`endif
         S_SKIP:   if (r_cnt == LAST) w_nxt = S_STREAM;
         S_STREAM: if (w_acc && r_cnt == LAST) w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state != S_IDLE);
      bus.c_ready = (r_state == S_STREAM) & (~r_pv | bus.p_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (w_nxt != r_state)
         r_cnt <= '0;
      else if (r_state inside {S_KEY, S_FRAME, S_MIX, S_SKIP} || w_acc)
         r_cnt <= r_cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key <= '0;
         r_frm <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_key <= key;
         r_frm <= frame;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_r1 <= '0;
         r_r2 <= '0;
         r_r3 <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_r1 <= '0;
               r_r2 <= '0;
               r_r3 <= '0;
            end
            S_KEY, S_FRAME: begin
               r_r1 <= {r_r1[17:0], w_f1 ^ w_in};
               r_r2 <= {r_r2[20:0], w_f2 ^ w_in};
               r_r3 <= {r_r3[21:0], w_f3 ^ w_in};
            end
            S_MIX, S_SKIP: begin
               r_r1 <= w_m1;
               r_r2 <= w_m2;
               r_r3 <= w_m3;
            end
            S_STREAM: begin
               if (w_acc) begin
                  r_r1 <= w_m1;
                  r_r2 <= w_m2;
                  r_r3 <= w_m3;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pv <= 1'b0;
         r_pb <= 1'b0;
         r_pl <= 1'b0;
      end else if (w_acc) begin
         r_pv <= 1'b1;
         r_pb <= bus.c_bit ^ w_z;
         r_pl <= (r_cnt == LAST);
      end else if (bus.p_ready) begin
         r_pv <= 1'b0;
      end
   end

   assign bus.p_valid = r_pv;
   assign bus.p_bit   = r_pb;
   assign bus.p_last  = r_pl;

endmodule

// File: tb/tb_a5_1_decryptor.sv
// Scoreboard bench for a5_1_decryptor against an integer A5/1 model.
// Honours A51_DEC_UPLINK_EN for keystream offset and setup latency.
`timescale 1ns/1ps
module tb_a5_1_decryptor;
   localparam int BL = 114;
`ifdef A51_DEC_UPLINK_EN
   localparam int OFS = 114;
   localparam int LAT = 301;
   localparam logic [15:0] KV16 = 16'h24FD;
`else
   localparam int OFS = 0;
   localparam int LAT = 187;
   localparam logic [15:0] KV16 = 16'h534E;
`endif
   localparam logic [63:0] VKEY = 64'hEFCDAB8967452312;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] key = '0;
   logic [21:0] frame = '0;
   logic        busy;

   a5_1_decryptor_if bif();

   a5_1_decryptor #(.BURST_LEN(BL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .key     (key),
      .frame   (frame),
      .busy    (busy),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   exp_t exp_q[$];
   logic got_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   logic hold = 1'b0;
   logic hold_b, hold_l;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endfunction

   function automatic int unsigned par(int unsigned v);
      return $countones(v) & 1;
   endfunction

   // reference A5/1 in the classic word-mask formulation
   function automatic logic [227:0] a51(logic [63:0] k, logic [21:0] f);
      int unsigned r1 = 0, r2 = 0, r3 = 0, b, m;
      logic [227:0] ks = '0;
      for (int i = 0; i < 86; i++) begin
         if (i < 64) b = k[i];
         else        b = f[i-64];
         r1 = ((r1 << 1) & 32'h07FFFF) | par(r1 & 32'h072000);
         r2 = ((r2 << 1) & 32'h3FFFFF) | par(r2 & 32'h300000);
         r3 = ((r3 << 1) & 32'h7FFFFF) | par(r3 & 32'h700080);
         r1 ^= b;
         r2 ^= b;
         r3 ^= b;
      end
      for (int i = 0; i < 328; i++) begin
         m = (((r1 >> 8) & 1) + ((r2 >> 10) & 1) + ((r3 >> 10) & 1)) >= 2;
         if (((r1 >> 8) & 1) == m)
            r1 = ((r1 << 1) & 32'h07FFFF) | par(r1 & 32'h072000);
         if (((r2 >> 10) & 1) == m)
            r2 = ((r2 << 1) & 32'h3FFFFF) | par(r2 & 32'h300000);
         if (((r3 >> 10) & 1) == m)
            r3 = ((r3 << 1) & 32'h7FFFFF) | par(r3 & 32'h700080);
         if (i >= 100)
            ks[i-100] = 1'(((r1 >> 18) ^ (r2 >> 21) ^ (r3 >> 22)) & 1);
      end
      return ks;
   endfunction

   function automatic logic [BL-1:0] slice(logic [227:0] ks);
      logic [BL-1:0] s;
      for (int i = 0; i < BL; i++) s[i] = ks[OFS+i];
      return s;
   endfunction

   initial begin
      bif.p_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bif.p_ready = 1'b1;
            1:       bif.p_ready = 1'($urandom_range(0, 1));
            default: bif.p_ready = 1'b0;
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hold = 1'b0;
         end else begin
            if (hold)
               chk("stall_stable", {bif.p_valid, bif.p_bit, bif.p_last},
                   {1'b1, hold_b, hold_l});
            if (bif.p_valid && bif.p_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra: got bit %b want none", bif.p_bit);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_bit", bif.p_bit, e.b);
                  chk("sb_last", bif.p_last, e.l);
               end
               got_q.push_back(bif.p_bit);
            end
            hold   = bif.p_valid && !bif.p_ready;
            hold_b = bif.p_bit;
            hold_l = bif.p_last;
         end
      end
   end

   task automatic start_frame(input logic [63:0] k, input logic [21:0] f);
      @(posedge clk);
      #1;
      start = 1'b1;
      key   = k;
      frame = f;
      @(posedge clk);
      #1;
      start = 1'b0;
      key   = {$urandom, $urandom};
      frame = 22'($urandom);
   endtask

   task automatic feed(input logic [BL-1:0] cb, input logic [BL-1:0] pb,
                       input int n, input int gap, input bit stall_after);
      exp_t e;
      int   t;
      bit   done;
      for (int i = 0; i < n; i++) begin
         t = 0;
         done = 0;
         while (!done) begin
            @(posedge clk);
            #1;
            bif.c_valid = ($urandom_range(0, 99) >= gap);
            bif.c_bit   = cb[i];
            @(negedge clk);
            if (bif.c_valid && bif.c_ready) begin
               done = 1;
               e.b = pb[i];
               e.l = (i == BL - 1);
               exp_q.push_back(e);
            end else if (++t > 2000) begin
               checks++;
               errors++;
               $display("FAIL feed_timeout: bit %0d not accepted want accept", i);
               bif.c_valid = 1'b0;
               return;
            end
         end
      end
      if (stall_after) rdy_mode = 2;
      @(posedge clk);
      #1;
      bif.c_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic check_kv(string nm);
      logic [15:0] v = '0;
      chk({nm, "_count"}, got_q.size(), BL);
      if (got_q.size() >= 16) begin
         for (int i = 0; i < 16; i++) v[15-i] = got_q[i];
         chk({nm, "_first16"}, v, KV16);
      end
   endtask

   initial begin
      logic [BL-1:0] zero = '0;
      logic [BL-1:0] kv, pt, ks2;
      logic [63:0]   rk;
      logic [21:0]   rf;
      int            first_hi;
      bit            bad;

      #600000;
      $display("FAIL watchdog: sim time exceeded want finish");
      $fatal(1);
   end

   initial begin
      logic [BL-1:0] zero;
      logic [BL-1:0] kv, pt, ks2;
      logic [63:0]   rk;
      logic [21:0]   rf;
      int            first_hi;
      bit            bad;

      zero = '0;
      bif.c_valid = 1'b0;
      bif.c_bit   = 1'b0;
      kv = slice(a51(VKEY, 22'h134));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_c_ready", bif.c_ready, 0);
      chk("rst_p_valid", bif.p_valid, 0);
      chk("rst_p_bit", bif.p_bit, 0);
      chk("rst_p_last", bif.p_last, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // setup latency with a stray start in the middle of key load
      got_q.delete();
      start_frame(VKEY, 22'h134);
      first_hi = -1;
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clk);
         if (bif.c_ready && first_hi < 0) first_hi = k;
         if (k == 50) begin
            start = 1'b1;
            key   = ~VKEY;
         end
         if (k == 51) start = 1'b0;
      end
      chk("setup_latency", first_hi, LAT);
      feed(zero, kv, BL, 0, 0);
      wait_drain();
      check_kv("kv");
      chk("idle_busy", busy, 0);

      rdy_mode = 1;
      got_q.delete();
      start_frame(VKEY, 22'h134);
      feed(zero, kv, BL, 40, 0);
      wait_drain();
      rdy_mode = 0;
      check_kv("bp");

      for (int r = 0; r < 2; r++) begin
         rk = {$urandom, $urandom};
         rf = 22'($urandom);
         for (int i = 0; i < BL; i++) pt[i] = 1'($urandom_range(0, 1));
         ks2 = slice(a51(rk, rf));
         rdy_mode = 1;
         got_q.delete();
         start_frame(rk, rf);
         feed(pt ^ ks2, pt, BL, 20, 0);
         wait_drain();
         rdy_mode = 0;
         chk("rt_count", got_q.size(), BL);
      end

      start_frame(VKEY, 22'h134);
      feed(zero, kv, 40, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_c_ready", bif.c_ready, 0);
      chk("mid_p_valid", bif.p_valid, 0);
      chk("mid_p_bit", bif.p_bit, 0);
      chk("mid_p_last", bif.p_last, 0);
      chk("mid_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      got_q.delete();
      start_frame(VKEY, 22'h134);
      feed(zero, kv, BL, 0, 0);
      wait_drain();
      check_kv("rst_rerun");

      // back-to-back: restart while the last bit of frame 0x134 is held
      start_frame(VKEY, 22'h134);
      feed(zero, kv, BL, 0, 1);
      chk("b2b_busy_fall", busy, 0);
      chk("b2b_pending", bif.p_valid, 1);
      ks2 = slice(a51(VKEY, 22'h135));
      start_frame(VKEY, 22'h135);
      bad = 0;
      for (int k = 0; k < LAT + 60; k++) begin
         @(negedge clk);
         if (bif.c_ready) bad = 1;
      end
      chk("b2b_cready_blocked", bad, 0);
      chk("b2b_still_pending", bif.p_valid, 1);
      rdy_mode = 0;
      wait_drain();
      got_q.delete();
      feed(zero, ks2, BL, 0, 0);
      wait_drain();
      chk("b2b_count", got_q.size(), BL);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
